// File: rtl/wb_master_bridge.sv
// wb_master_bridge: Wishbone B3 classic-cycle master for one CPU memory port.
// Turns a level-held CPU request into a single bus cycle and stalls the pipeline until ack, timeout or flush.
`default_nettype none

module wb_master_bridge #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        cpu_ce_i,
  input  logic        cpu_we_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [3:0]  cpu_sel_i,
  input  logic [31:0] cpu_data_i,
  output logic [31:0] cpu_data_o,

  input  logic        stall_i,
  input  logic        flush_i,
  output logic        stallreq_o,
  output logic        err_o,

  output logic [31:0] wb_addr_o,
  output logic [31:0] wb_data_o,
  input  logic [31:0] wb_data_i,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic        wb_ack_i
);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] BUSY       = 2'd1;
  localparam logic [1:0] WAIT_STALL = 2'd2;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  if ((TIMEOUT_CYCLES < 2) || (TIMEOUT_CYCLES > 65535)) begin : g_timeout_range_check
    $error("wb_master_bridge: TIMEOUT_CYCLES out of range 2..65535");
  end

  logic [1:0]  state;
  logic [15:0] cnt;
  logic [31:0] rd_buf;
  logic        bus_active;
  logic        timeout;

  // stb and cyc come from one flop so they can never diverge.
  assign wb_stb_o = bus_active;
  assign wb_cyc_o = bus_active;

  assign timeout = (state == BUSY) && (cnt == CNT_LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      cnt        <= 16'd0;
      rd_buf     <= 32'd0;
      bus_active <= 1'b0;
      wb_addr_o  <= 32'd0;
      wb_data_o  <= 32'd0;
      wb_sel_o   <= 4'd0;
      wb_we_o    <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_ce_i && !flush_i) begin
            wb_addr_o  <= cpu_addr_i;
            wb_data_o  <= cpu_data_i;
            wb_sel_o   <= cpu_sel_i;
            wb_we_o    <= cpu_we_i;
            bus_active <= 1'b1;
            cnt        <= 16'd0;
            state      <= BUSY;
          end
        end

        BUSY: begin
          if (flush_i) begin
            // Abandon the cycle; any ack arriving now or later is ignored.
            bus_active <= 1'b0;
            wb_addr_o  <= 32'd0;
            wb_data_o  <= 32'd0;
            wb_sel_o   <= 4'd0;
            wb_we_o    <= 1'b0;
            rd_buf     <= 32'd0;
            state      <= IDLE;
          end else if (wb_ack_i) begin
            bus_active <= 1'b0;
            wb_addr_o  <= 32'd0;
            wb_data_o  <= 32'd0;
            wb_sel_o   <= 4'd0;
            wb_we_o    <= 1'b0;
            rd_buf     <= wb_we_o ? 32'd0 : wb_data_i;
            state      <= stall_i ? WAIT_STALL : IDLE;
          end else if (timeout) begin
            bus_active <= 1'b0;
            wb_addr_o  <= 32'd0;
            wb_data_o  <= 32'd0;
            wb_sel_o   <= 4'd0;
            wb_we_o    <= 1'b0;
            rd_buf     <= 32'd0;
            err_o      <= 1'b1;
            state      <= stall_i ? WAIT_STALL : IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        WAIT_STALL: begin
          if (!stall_i || flush_i) begin
            state <= IDLE;
          end
        end

        default: begin
          bus_active <= 1'b0;
          wb_addr_o  <= 32'd0;
          wb_data_o  <= 32'd0;
          wb_sel_o   <= 4'd0;
          wb_we_o    <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    stallreq_o = 1'b0;
    cpu_data_o = 32'd0;
    case (state)
      IDLE: begin
        stallreq_o = cpu_ce_i && !flush_i;
      end
      BUSY: begin
        stallreq_o = !(wb_ack_i || flush_i || timeout);
        if (wb_ack_i && !wb_we_o) begin
          cpu_data_o = wb_data_i;
        end
      end
      WAIT_STALL: begin
        cpu_data_o = rd_buf;
      end
      default: begin
        stallreq_o = 1'b0;
        cpu_data_o = 32'd0;
      end
    endcase
  end

endmodule

`default_nettype wire
